if_prefetch_unit: RTL and testbench

//  Clocked instruction-fetch stage with in-order prefetch FIFO and pipelined memory request/response port.

---
 rtl/if_prefetch_unit_if.sv | 22 ++
 rtl/if_prefetch_unit.sv | 126 ++++++++++++
 tb/tb_if_prefetch_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/if_prefetch_unit_if.sv
// rtl/if_prefetch_unit_if.sv - pipelined instruction memory read port
// master: fetch unit issuing reads; slave: memory returning in-order responses.
interface if_prefetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [INST_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - instruction fetch stage with prefetch FIFO
// Issues up to MAX_OUTST pipelined reads, buffers words with their PC, drops stale reads after a redirect.
module if_prefetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                INST_W    = 32,
  parameter int                DEPTH     = 4,
  parameter int                MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                br,
  input  logic [ADDR_W-1:0]   br_target,
  if_prefetch_unit_if.master  mem,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_W-1:0]   inst_o,
  output logic [ADDR_W-1:0]   pc_o,
  output logic                stallreq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_W / 8 - 1);
  localparam logic [CW:0]       DEPTH_C    = (CW+1)'(DEPTH);
  localparam logic [OW-1:0]     MAXO_C     = OW'(MAX_OUTST);
  localparam logic [QW-1:0]     QLAST      = QW'(MAX_OUTST - 1);

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [OW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [QW-1:0]     pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;

  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [INST_W-1:0] fifo_inst [DEPTH];
  logic [ADDR_W-1:0] pcq       [MAX_OUTST];

  logic        grant, keep, drop, pop;
  logic [CW:0] occ;

  function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
    return (p == QLAST) ? '0 : p + 1'b1;
  endfunction

  // Space is reserved at issue time, so a returning read always finds a free FIFO slot.
  assign occ          = (CW+1)'(outst_q) + (CW+1)'(fifo_cnt_q);
  assign mem.mem_req  = !rst && !br && (occ < DEPTH_C) && (outst_q < MAXO_C);
  assign mem.mem_addr = fetch_pc_q;
  assign grant        = mem.mem_req && mem.mem_gnt;

  assign inst_valid = (fifo_cnt_q != '0);
  assign inst_o     = inst_valid ? fifo_inst[rd_ptr_q] : '0;
  assign pc_o       = inst_valid ? fifo_pc[rd_ptr_q] : '0;
  assign stallreq   = !inst_valid;

  always_comb begin
    state_d    = state_q;
    drop       = mem.mem_rvalid && (discard_q != '0);
    keep       = mem.mem_rvalid && (discard_q == '0) && !br && !rst;
    pop        = inst_valid && inst_ready && !br;
    outst_d    = outst_q + OW'(grant) - OW'(mem.mem_rvalid);
    discard_d  = discard_q - OW'(drop);
    fetch_pc_d = grant ? fetch_pc_q + PC_STEP : fetch_pc_q;
    pcq_wr_d   = grant ? q_next(pcq_wr_q) : pcq_wr_q;
    pcq_rd_d   = mem.mem_rvalid ? q_next(pcq_rd_q) : pcq_rd_q;
    wr_ptr_d   = wr_ptr_q + AW'(keep);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    fifo_cnt_d = fifo_cnt_q + CW'(keep) - CW'(pop);

    // Every read still in flight after a redirect belongs to the old path.
    if (br) begin
      discard_d  = outst_d;
      fetch_pc_d = br_target & ALIGN_MASK;
      fifo_cnt_d = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end

    unique case (state_q)
      S_RUN:   if (br && discard_d != '0) state_d = S_DRAIN;
      S_DRAIN: if (discard_d == '0) state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      fifo_cnt_q <= fifo_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pcq_rd_q   <= pcq_rd_d;
      pcq_wr_q   <= pcq_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) pcq[pcq_wr_q] <= fetch_pc_q;
    if (keep) begin
      fifo_pc[wr_ptr_q]   <= pcq[pcq_rd_q];
      fifo_inst[wr_ptr_q] <= mem.mem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) occ <= DEPTH_C);
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) mem.mem_rvalid |-> outst_q != '0);
endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb/tb_if_prefetch_unit.sv - randomized bench for if_prefetch_unit against a queue-based model
module tb_if_prefetch_unit;
  localparam int AW = 32, IW = 32, DEPTH = 4, MAXO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, br, inst_valid, inst_ready, stallreq;
  logic [AW-1:0] br_target, pc_o;
  logic [IW-1:0] inst_o;

  if_prefetch_unit_if #(.ADDR_W(AW), .INST_W(IW)) mem_bus ();

  if_prefetch_unit #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .MAX_OUTST(MAXO), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .br(br), .br_target(br_target), .mem(mem_bus),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_o(inst_o), .pc_o(pc_o), .stallreq(stallreq)
  );

  typedef struct packed {logic [31:0] addr; logic stale;} pend_t;
  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;

  pend_t       pend[$];
  ent_t        fifo[$];
  logic [31:0] m_pc = 32'h0;
  int          total = 0, bad = 0, dut_grants = 0;
  bit          chk_en = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; drives one cycle, checks outputs, advances the model at the posedge.
  task automatic step(input bit r, input bit b, input logic [31:0] t, input bit g, input bit rv_en, input bit rdy);
    bit    rv, exp_req, mgrant, v;
    pend_t p;
    ent_t  e;
    rst = r; br = b; br_target = t; inst_ready = rdy; mem_bus.mem_gnt = g;
    rv = rv_en && !r && (pend.size() > 0);
    mem_bus.mem_rvalid = rv;
    mem_bus.mem_rdata  = rv ? mem_word(pend[0].addr) : $urandom;
    #1;
    v       = fifo.size() > 0;
    exp_req = !r && !b && (pend.size() + fifo.size() < DEPTH) && (pend.size() < MAXO);
    mgrant  = exp_req && g;
    if (mem_bus.mem_req && g) dut_grants++;
    if (chk_en) begin
      check("mem_req", 64'(mem_bus.mem_req), 64'(exp_req));
      check("mem_addr", 64'(mem_bus.mem_addr), 64'(m_pc));
      check("inst_valid", 64'(inst_valid), 64'(v));
      check("stallreq", 64'(stallreq), 64'(!v));
      check("pc_o", 64'(pc_o), v ? 64'(fifo[0].pc) : 64'h0);
      check("inst_o", 64'(inst_o), v ? 64'(fifo[0].inst) : 64'h0);
    end
    @(posedge clk);
    if (r) begin
      pend.delete();
      fifo.delete();
      m_pc = 32'h0;
    end else begin
      if (v && rdy && !b) void'(fifo.pop_front());
      if (rv) begin
        p = pend.pop_front();
        if (!p.stale && !b) begin
          e.pc = p.addr; e.inst = mem_word(p.addr);
          fifo.push_back(e);
        end
      end
      if (mgrant) begin
        p.addr = m_pc; p.stale = 1'b0;
        pend.push_back(p);
        m_pc = m_pc + 32'd4;
      end
      if (b) begin
        fifo.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
        m_pc = t & ~32'h3;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] tg;
    rst = 1'b1; br = 1'b0; br_target = '0; inst_ready = 1'b0;
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    chk_en = 1;
    step(1, 0, 0, 1, 0, 0);
    check("rst_valid", 64'(inst_valid), 64'h0);
    check("rst_stall", 64'(stallreq), 64'h1);
    check("rst_pc", 64'(pc_o), 64'h0);

    // sequential fetch, one-cycle memory
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 1);

    // decode stalled: fill exactly DEPTH entries, then drain in order
    step(1, 0, 0, 1, 0, 0);
    dut_grants = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 0);
    check("t2_grants", 64'(dut_grants), 64'd4);
    check("t2_head", 64'(pc_o), 64'h0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 1);

    // two reads in flight at redirect
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 1, 32'h100, 1, 0, 1);
    for (int i = 0; i < 20 && !inst_valid; i++) step(0, 0, 0, 1, 1, 1);
    check("t3_valid", 64'(inst_valid), 64'h1);
    check("t3_pc", 64'(pc_o), 64'h100);
    check("t3_inst", 64'(inst_o), 64'(mem_word(32'h100)));

    // misaligned redirect alongside a returning read
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 32'h102, 1, 1, 0);
    check("t4_addr", 64'(mem_bus.mem_addr), 64'h100);
    check("t4_empty", 64'(inst_valid), 64'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 1);

    // address wrap
    step(0, 1, 32'hFFFF_FFFC, 1, 1, 1);
    for (int i = 0; i < 10 && mem_bus.mem_addr == 32'hFFFF_FFFC; i++) step(0, 0, 0, 1, 1, 1);
    check("t5_wrap", 64'(mem_bus.mem_addr), 64'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 1);

    // reset with full FIFO and a simultaneous redirect
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1, 0);
    check("t6_full", 64'(inst_valid), 64'h1);
    step(1, 1, 32'h40, 1, 1, 0);
    check("t6_valid", 64'(inst_valid), 64'h0);
    check("t6_req", 64'(mem_bus.mem_req), 64'h0);
    check("t6_pc", 64'(mem_bus.mem_addr), 64'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tg = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), tg,
           ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 65));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
